mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max bus-state cycles awaiting m_ack before abort (1..255).
REQ-002 SHALL have ports:
  clk  input  1  clock, all state on rising edge
  rst_n  input  1  reset, asynchronous, active-low
  i_rd  input  1  instruction fetch request, level, held until i_busy low
  i_addr  input  64  fetch address
  i_data  output  32  fetch data (m_rdata[31:0])
  i_busy  output  1  fetch pending; drives pipeline fetch stall
  d_rd  input  1  data read request, level
  d_wr  input  1  data write request, level
  d_addr  input  64  data address
  d_wdata  input  64  write data
  d_rdata  output  64  read data
  d_busy  output  1  data access pending; drives pipeline memory stall
  err  output  1  one-cycle pulse: granted access timed out
  m_rd  output  1  bus read strobe
  m_wr  output  1  bus write strobe
  m_addr  output  64  bus address
  m_wdata  output  64  bus write data
  m_rdata  input  64  bus read data, valid with m_ack
  m_ack  input  1  bus completion, one cycle

Function
REQ-003 SHALL implement FSM states IDLE, BUS_I, BUS_D, DONE_I, DONE_D.
REQ-004 IDLE: d_rd|d_wr high -> BUS_D; else i_rd high -> BUS_I; else stay.
REQ-005 Data port SHALL have fixed priority over instruction port when both request in same IDLE cycle.
REQ-006 On grant SHALL register m_addr and m_wdata from the granted port; m_rd/m_wr asserted first cycle of BUS_x (1 cycle after request seen in IDLE).
REQ-007 BUS_D: m_wr=1 if d_wr sampled at grant, else m_rd=1; d_rd&d_wr both high SHALL be treated as write.
REQ-008 BUS_I: m_rd=1, m_wr=0.
REQ-009 m_rd/m_wr/m_addr/m_wdata SHALL hold stable throughout BUS_x until cycle m_ack sampled high.
REQ-010 m_ack high in BUS_I: capture m_rdata[31:0] into i_data -> DONE_I; BUS_D read: capture m_rdata into d_rdata -> DONE_D; BUS_D write: d_rdata unchanged -> DONE_D.
REQ-011 m_ack in IDLE or DONE_x SHALL be ignored.
REQ-012 Strobes SHALL be 0 in IDLE and DONE_x.
REQ-013 DONE_x SHALL last exactly one cycle, then IDLE; no arbitration in DONE_x.
REQ-014 i_busy = i_rd & ~(state==DONE_I); d_busy = (d_rd|d_wr) & ~(state==DONE_D); combinational.
REQ-015 Requester SHALL see busy low for exactly one cycle per completed access; a request held past DONE_x SHALL be treated as a new access.
REQ-016 Timeout counter (8 bit) SHALL clear on grant, increment each BUS_x cycle without m_ack; reaching TIMEOUT SHALL drop strobes, go DONE_x, pulse err in DONE_x, leave i_data/d_rdata unchanged.
REQ-017 m_ack in the same cycle counter reaches TIMEOUT SHALL complete normally, no err.
REQ-018 i_data, d_rdata SHALL hold value until next successful capture for that port.
REQ-019 Request deasserted while in BUS_x SHALL not abort the bus access; it completes and result is discarded by the requester.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, m_rd=m_wr=0, err=0, counter=0, m_addr=m_wdata=0, i_data=0, d_rdata=0.
REQ-021 Reset during BUS_x SHALL drop strobes immediately; no completion or err after release.
REQ-022 First grant no earlier than first rising edge after rst_n rises.

Verification
REQ-023 i_rd=1, i_addr=0x1000, m_ack 3 cycles after m_rd with m_rdata=0x00000013 -> m_rd 3 cycles, i_data=0x13, i_busy low one cycle, err=0.
REQ-024 d_wr=1 and i_rd=1 same cycle, d_addr=0x2000, d_wdata=0xDEADBEEF -> BUS_D first (m_wr, m_addr=0x2000), then DONE_D, IDLE, BUS_I.
REQ-025 d_rd=d_wr=1 -> m_wr=1, m_rd=0, d_rdata unchanged.
REQ-026 i_rd=1, m_ack never, TIMEOUT=255 -> strobe 255 cycles, err pulse 1 cycle, i_busy low 1 cycle, i_data unchanged.
REQ-027 rst_n low mid BUS_D after 2 cycles -> m_wr=0 same cycle, state IDLE, all outputs zero; m_ack afterwards ignored.
REQ-028 i_rd held high continuously, ack latency 1 -> one completion every 4 cycles (IDLE, BUS_I, DONE_I), i_busy low only in DONE_I.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the fetch port, the data port and the shared memory bus of the arbiter
interface mem_arbiter_if;
  logic        i_rd;
  logic [63:0] i_addr;
  logic [31:0] i_data;
  logic        i_busy;
  logic        d_rd;
  logic        d_wr;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_busy;
  logic        err;
  logic        m_rd;
  logic        m_wr;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ack;

  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ack,
    output i_data, i_busy, d_rdata, d_busy, err, m_rd, m_wr, m_addr, m_wdata
  );

  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ack,
    input  i_data, i_busy, d_rdata, d_busy, err, m_rd, m_wr, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the fetch and data ports, data first, with a bus timeout
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, DONE_I, DONE_D} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        m_rd_q, m_rd_d;
  logic        m_wr_q, m_wr_d;
  logic [63:0] m_addr_q, m_addr_d;
  logic [63:0] m_wdata_q, m_wdata_d;
  logic [31:0] i_data_q, i_data_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  assign cnt_inc = cnt_q + 8'd1;

  // arbitration, bus hold, completion capture and timeout abort
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_rd | bus.d_wr) begin
          state_d   = BUS_D;
          cnt_d     = '0;
          m_rd_d    = ~bus.d_wr;
          m_wr_d    = bus.d_wr;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
        end else if (bus.i_rd) begin
          state_d   = BUS_I;
          cnt_d     = '0;
          m_rd_d    = 1'b1;
          m_wr_d    = 1'b0;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
        end
      end
      BUS_I, BUS_D: begin
        if (bus.m_ack) begin
          state_d   = (state_q == BUS_I) ? DONE_I : DONE_D;
          m_rd_d    = 1'b0;
          m_wr_d    = 1'b0;
          i_data_d  = (state_q == BUS_I) ? bus.m_rdata[31:0] : i_data_q;
          d_rdata_d = (state_q == BUS_D && m_rd_q) ? bus.m_rdata : d_rdata_q;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO) begin
            state_d = (state_q == BUS_I) ? DONE_I : DONE_D;
            m_rd_d  = 1'b0;
            m_wr_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and bus registers, cleared asynchronously so strobes drop the moment reset asserts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.m_rd    = m_rd_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_data  = i_data_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.err     = err_q;
  assign bus.i_busy  = bus.i_rd & (state_q != DONE_I);
  assign bus.d_busy  = (bus.d_rd | bus.d_wr) & (state_q != DONE_D);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus checked against a transaction-level arbiter model
module tb_mem_arbiter;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // model: the access in flight, the port completing this cycle, and each port's last result
  bit          act, pd, wr, ee;
  logic [63:0] ea, ew, edr;
  logic [31:0] eid;
  int          age, lat, done;
  int          lat_sel = -1;
  bit          rrand = 1'b1;
  bit          afix = 1'b0;
  logic [63:0] rfix = '0;
  int          strb, ilow, errs;
  logic [31:0] sav_i;
  logic [63:0] sav_d;
  logic        ri, rr, rw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    act = 1'b0; done = 0; ee = 1'b0; eid = '0; edr = '0;
  endtask

  task automatic chk_all(input logic ird, input logic drd, input logic dwr);
    chk("m_rd", 64'(bus.m_rd), 64'(act & ~(pd & wr)));
    chk("m_wr", 64'(bus.m_wr), 64'(act & pd & wr));
    if (act) chk("m_addr", bus.m_addr, ea);
    if (act & pd & wr) chk("m_wdata", bus.m_wdata, ew);
    chk("i_data", 64'(bus.i_data), 64'(eid));
    chk("d_rdata", bus.d_rdata, edr);
    chk("err", 64'(bus.err), 64'(ee));
    chk("i_busy", 64'(bus.i_busy), 64'(ird & (done != 1)));
    chk("d_busy", 64'(bus.d_busy), 64'((drd | dwr) & (done != 2)));
  endtask

  // one clock: drive at the falling edge, check, then advance the model across the rising edge
  task automatic cyc(input logic ird, input logic drd, input logic dwr);
    logic ack;
    int   nd;
    bit   ne;
    bus.i_rd    = ird;
    bus.d_rd    = drd;
    bus.d_wr    = dwr;
    bus.i_addr  = afix ? 64'h1000 : {$urandom, $urandom};
    bus.d_addr  = afix ? 64'h2000 : {$urandom, $urandom};
    bus.d_wdata = afix ? 64'hDEADBEEF : {$urandom, $urandom};
    bus.m_rdata = rrand ? {$urandom, $urandom} : rfix;
    ack = act ? (age == lat) : ($urandom_range(0, 3) == 0);
    bus.m_ack = ack;
    #1;
    chk_all(ird, drd, dwr);
    strb += int'(bus.m_rd | bus.m_wr);
    ilow += int'(ird & ~bus.i_busy);
    errs += int'(bus.err);
    nd = 0;
    ne = 1'b0;
    if (act) begin
      if (ack) begin
        nd = pd ? 2 : 1;
        act = 1'b0;
        if (!pd) eid = bus.m_rdata[31:0];
        else if (!wr) edr = bus.m_rdata;
      end else begin
        age++;
        if (age == TO) begin
          nd = pd ? 2 : 1;
          ne = 1'b1;
          act = 1'b0;
        end
      end
    end else if (done == 0 && (drd | dwr | ird)) begin
      act = 1'b1;
      pd  = drd | dwr;
      wr  = dwr;
      ea  = pd ? bus.d_addr : bus.i_addr;
      ew  = bus.d_wdata;
      age = 0;
      lat = (lat_sel >= 0) ? lat_sel :
            (($urandom_range(0, 39) == 0) ? 254 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 4)));
    end
    done = nd;
    ee = ne;
    @(negedge clk);
  endtask

  initial begin
    bus.i_rd = 0; bus.d_rd = 0; bus.d_wr = 0; bus.m_ack = 0;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.m_rdata = '0;
    mreset();
    @(negedge clk);
    #1;
    chk_all(1'b0, 1'b0, 1'b0);
    chk("rst_m_addr", bus.m_addr, 64'h0);
    chk("rst_m_wdata", bus.m_wdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // fetch with ack on the third strobe cycle
    afix = 1'b1; rrand = 1'b0; rfix = 64'hFFFF_FFFF_0000_0013; lat_sel = 2;
    strb = 0; ilow = 0; errs = 0;
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("fetch_strobes", 64'(strb), 64'd3);
    chk("fetch_busy_low", 64'(ilow), 64'd1);
    chk("fetch_err", 64'(errs), 64'd0);
    chk("fetch_data", 64'(bus.i_data), 64'h13);

    // simultaneous write and fetch: data port first
    rrand = 1'b1; lat_sel = 1;
    cyc(1'b1, 1'b0, 1'b1);
    chk("prio_m_wr", 64'(bus.m_wr), 64'd1);
    chk("prio_m_addr", bus.m_addr, 64'h2000);
    chk("prio_m_wdata", bus.m_wdata, 64'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("then_m_rd", 64'(bus.m_rd), 64'd1);
    chk("then_m_addr", bus.m_addr, 64'h1000);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // random traffic, including request drops mid-access, spurious acks and timeouts
    afix = 1'b0; lat_sel = -1;
    ri = 0; rr = 0; rw = 0;
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) ri = ~ri;
      if ($urandom_range(0, 7) == 0) rr = ~rr;
      if ($urandom_range(0, 7) == 0) rw = ~rw;
      cyc(ri, rr, rw);
    end
    repeat (300) cyc(1'b0, 1'b0, 1'b0);

    // read and write together count as a write and leave d_rdata alone
    lat_sel = 1; sav_d = edr;
    cyc(1'b0, 1'b1, 1'b1);
    chk("rw_m_wr", 64'(bus.m_wr), 64'd1);
    chk("rw_m_rd", 64'(bus.m_rd), 64'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rw_d_rdata", bus.d_rdata, sav_d);

    // fetch that is never acknowledged times out
    lat_sel = 1000; sav_i = eid; strb = 0; ilow = 0; errs = 0;
    repeat (257) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("to_strobes", 64'(strb), 64'd255);
    chk("to_err_pulses", 64'(errs), 64'd1);
    chk("to_busy_low", 64'(ilow), 64'd1);
    chk("to_i_data", 64'(bus.i_data), 64'(sav_i));

    // back-to-back fetches with one wait cycle complete every four clocks
    lat_sel = 1; ilow = 0;
    repeat (40) cyc(1'b1, 1'b0, 1'b0);
    chk("b2b_busy_low", 64'(ilow), 64'd10);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // reset in the middle of a write
    lat_sel = 1000;
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    chk("pre_rst_m_wr", 64'(bus.m_wr), 64'd1);
    bus.d_wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk_all(1'b0, 1'b0, 1'b0);
    chk("rst_mid_m_addr", bus.m_addr, 64'h0);
    chk("rst_mid_m_wdata", bus.m_wdata, 64'h0);
    bus.m_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
